// File: rtl/booth_pkg.sv
// Shared control/status encoding for the radix-2 Booth multiplier control unit and datapath.
package booth_pkg;

    localparam int CTRL_W = 10;
    localparam int STAT_W = 2;

    localparam int CTRL_LD_A     = 9;
    localparam int CTRL_LD_B     = 8;
    localparam int CTRL_LD_CONT  = 7;
    localparam int CTRL_SET_EF   = 6;
    localparam int CTRL_RST_X    = 5;
    localparam int CTRL_RST_EF   = 4;
    localparam int CTRL_SUB_X    = 3;
    localparam int CTRL_SUB_CONT = 2;
    localparam int CTRL_ADD_X    = 1;
    localparam int CTRL_SHIFT_XB = 0;

    localparam int STAT_B0  = 1;
    localparam int STAT_FIN = 0;

    // Field order mirrors the bit indices above, so a plain cast decodes the control word.
    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic ld_cont;
        logic set_ef;
        logic rst_x;
        logic rst_ef;
        logic sub_x;
        logic sub_cont;
        logic add_x;
        logic shift_xb;
    } booth_ctrl_t;

endpackage

// File: rtl/booth_dp_if.sv
// Control-unit <-> datapath bus: operands and control in, status/product/flags out.
interface booth_dp_if #(
    parameter int N = 8
);
    import booth_pkg::*;

    logic [N-1:0]      a_in;
    logic [N-1:0]      b_in;
    logic [CTRL_W-1:0] control;
    logic [STAT_W-1:0] status;
    logic [2*N-1:0]    product;
    logic              done;
    logic              err;

    modport master (
        output a_in, b_in, control,
        input  status, product, done, err
    );

    modport slave (
        input  a_in, b_in, control,
        output status, product, done, err
    );

endinterface

// File: rtl/booth_addsub.sv
// Combinational modulo-2^W adder/subtractor for the Booth accumulator.
module booth_addsub #(
    parameter int W = 9
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] a,
    input  logic         sub,
    output logic [W-1:0] result
);

    always_comb begin
        if (sub) result = x - a;
        else     result = x + a;
    end

endmodule

// File: rtl/booth_dp.sv
// Radix-2 Booth multiplier datapath: A/B/X/cnt/EF registers driven by the control word.
// Optional sticky illegal-control detector enabled by defining BOOTH_DP_CTRL_CHECK_EN.
module booth_dp
    import booth_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input logic         clk,
    input logic         rstn,
    booth_dp_if.slave   bus
);

    booth_ctrl_t ctrl;

    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N:0]    x_q, x_d;
    logic [N:0]    x_arith;
    logic [N:0]    a_sxt;
    logic [N:0]    sum;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ef_q, ef_d;
    logic          fin;

    assign ctrl  = booth_ctrl_t'(bus.control);
    assign fin   = (cnt_q == '0);
    assign a_sxt = {a_q[N-1], a_q};

    booth_addsub #(
        .W (N + 1)
    ) u_addsub (
        .x      (x_q),
        .a      (a_sxt),
        .sub    (ctrl.sub_x),
        .result (sum)
    );

    // NOTE: every variable assigned here gets a hold default first, so no path leaves it unassigned (no latch).
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        x_arith = x_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        ef_d    = ef_q;

        if (ctrl.ld_a) a_d = bus.a_in;

        // SUB_X drives the adder's sub input, so it also wins when ADD_X is asserted alongside.
        if (ctrl.rst_x)                    x_arith = '0;
        else if (ctrl.sub_x || ctrl.add_x) x_arith = sum;

        x_d = x_arith;
        // Shift acts on the post-arithmetic X, giving one combined update per cycle.
        if (ctrl.shift_xb) {x_d, b_d} = $signed({x_arith, b_q}) >>> 1;

        if (ctrl.ld_b) b_d = bus.b_in;

        if (ctrl.ld_cont)               cnt_d = CW'(N - 1);
        else if (ctrl.sub_cont && !fin) cnt_d = cnt_q - CW'(1);

        if (ctrl.rst_ef)      ef_d = 1'b0;
        else if (ctrl.set_ef) ef_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q   <= '0;
            b_q   <= '0;
            x_q   <= '0;
            cnt_q <= '0;
            ef_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            x_q   <= x_d;
            cnt_q <= cnt_d;
            ef_q  <= ef_d;
        end
    end

    assign bus.status[STAT_B0]  = b_q[0];
    assign bus.status[STAT_FIN] = fin;
    assign bus.product          = {x_q[N-1:0], b_q};
    assign bus.done             = ef_q;

`ifdef BOOTH_DP_CTRL_CHECK_EN
    logic err_q, err_d;
    logic ctrl_bad;

    assign ctrl_bad = (ctrl.add_x && ctrl.sub_x)
                    || (ctrl.sub_cont && fin)
                    || (ctrl.shift_xb && (ctrl.ld_a || ctrl.ld_b || ctrl.rst_x));
    assign err_d    = err_q | ctrl_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_dp.sv
// Self-checking bench for booth_dp (N=8): directed checks plus scoreboarded random multiplies.
module tb_booth_dp;
    import booth_pkg::*;

    localparam int N = 8;

`ifdef BOOTH_DP_CTRL_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    localparam logic [9:0] C_LD_A     = 10'b1 << CTRL_LD_A;
    localparam logic [9:0] C_LD_B     = 10'b1 << CTRL_LD_B;
    localparam logic [9:0] C_LD_CONT  = 10'b1 << CTRL_LD_CONT;
    localparam logic [9:0] C_SET_EF   = 10'b1 << CTRL_SET_EF;
    localparam logic [9:0] C_RST_X    = 10'b1 << CTRL_RST_X;
    localparam logic [9:0] C_RST_EF   = 10'b1 << CTRL_RST_EF;
    localparam logic [9:0] C_SUB_X    = 10'b1 << CTRL_SUB_X;
    localparam logic [9:0] C_SUB_CONT = 10'b1 << CTRL_SUB_CONT;
    localparam logic [9:0] C_ADD_X    = 10'b1 << CTRL_ADD_X;
    localparam logic [9:0] C_SHIFT_XB = 10'b1 << CTRL_SHIFT_XB;

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] exp_q[$];

    booth_dp_if #(.N(N)) bus ();

    booth_dp #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one control word for exactly one rising edge; return 1 time unit after it.
    task automatic cycle(input logic [9:0] c);
        bus.control = c;
        @(posedge clk);
        #1;
        bus.control = '0;
    endtask

    task automatic pulse_reset();
        #2 rstn = 1'b0;
        #2 rstn = 1'b1;
    endtask

    // Reference: the product is plain signed multiplication; control follows the Booth recoding rule.
    task automatic do_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [9:0]  c;
        logic        prev;
        logic        b0;
        logic        fin;
        p = $signed(a) * $signed(b);
        exp_q.push_back(p);
        bus.a_in = a;
        bus.b_in = b;
        cycle(C_LD_A | C_LD_B | C_LD_CONT | C_RST_X | C_RST_EF);
        prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            b0  = bus.status[1];
            fin = bus.status[0];
            check($sformatf("fin_iter%0d", i), 32'(fin), 32'(i == N - 1));
            c = C_SHIFT_XB;
            if (b0 && !prev)      c = c | C_SUB_X;
            else if (!b0 && prev) c = c | C_ADD_X;
            if (!fin) c = c | C_SUB_CONT;
            prev = b0;
            cycle(c);
        end
        cycle(C_SET_EF);
        cycle('0);
    endtask

    // Monitor: pops the expected product whenever done rises.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (bus.done && !prev_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_done: got product 0x%0h, expected no result", bus.product);
            end else begin
                check("sb_product", 32'(bus.product), 32'(exp_q.pop_front()));
                check("sb_fin_at_done", 32'(bus.status[0]), 32'd1);
                check("sb_err_at_done", 32'(bus.err), 32'd0);
            end
        end
        prev_done = bus.done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        bus.control = '0;
        bus.a_in    = '0;
        bus.b_in    = '0;
        #13;
        check("reset_status",  32'(bus.status),  32'h1);
        check("reset_product", 32'(bus.product), 32'h0);
        check("reset_done",    32'(bus.done),    32'h0);
        check("reset_err",     32'(bus.err),     32'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Mid-sequence async reset with X != 0.
        bus.a_in = 8'd5;
        bus.b_in = 8'd1;
        cycle(C_LD_A | C_LD_B | C_LD_CONT | C_RST_X | C_RST_EF);
        cycle(C_SUB_X | C_SHIFT_XB | C_SUB_CONT);
        check("abort_pre_product", 32'(bus.product), 32'hFD80);
        #2 rstn = 1'b0;
        #1;
        check("abort_status",  32'(bus.status),  32'h1);
        check("abort_product", 32'(bus.product), 32'h0);
        check("abort_done",    32'(bus.done),    32'h0);
        check("abort_err",     32'(bus.err),     32'h0);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Counter saturation.
        cycle(C_LD_CONT);
        check("cnt_loaded_fin", 32'(bus.status[0]), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            cycle(C_SUB_CONT);
            check($sformatf("cnt_dec%0d_fin", i), 32'(bus.status[0]), 32'(i == 7));
        end
        check("cnt_err_before_8th", 32'(bus.err), 32'd0);
        cycle(C_SUB_CONT);
        check("cnt_sat_fin", 32'(bus.status[0]), 32'd1);
        check("cnt_err_8th", 32'(bus.err), 32'(CHK));
        cycle('0);
        cycle('0);
        cycle(C_LD_CONT);
        check("cnt_err_sticky", 32'(bus.err), 32'(CHK));
        pulse_reset();
        check("cnt_err_cleared", 32'(bus.err), 32'd0);

        // Simultaneous controls.
        bus.a_in = 8'd3;
        bus.b_in = 8'h01;
        cycle(C_LD_A | C_LD_B | C_RST_X);
        cycle(C_SUB_X | C_SHIFT_XB);
        check("subshift_product", 32'(bus.product), 32'hFE80);
        check("subshift_b0",      32'(bus.status[1]), 32'd0);
        check("subshift_err",     32'(bus.err), 32'd0);
        cycle(C_ADD_X | C_SUB_X);
        check("addsub_product", 32'(bus.product), 32'hFB80);
        check("addsub_err",     32'(bus.err), 32'(CHK));
        pulse_reset();

        // Directed then random multiplies through the scoreboard.
        do_mul(8'd3, 8'd5);
        do_mul(8'hFD, 8'd5);
        do_mul(8'd7, 8'hFE);
        do_mul(8'h80, 8'h80);
        do_mul(8'd0, 8'hFF);
        do_mul(8'h7F, 8'h80);
        for (int i = 0; i < 20; i++) begin
            do_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        // Result must hold while only idle cycles follow.
        cycle('0);
        cycle('0);
        check("hold_product", 32'(bus.done), 32'd1);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
